// File: rtl/cpu6502_intc_pkg.sv
// Shared register map, NMI state encoding and helpers for the 6502 interrupt controller.
package cpu6502_intc_pkg;

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_NMICTL  = 3'd3;
  localparam logic [2:0] REG_TRIGGER = 3'd4;

  localparam int NMI_RECOVER_CYCLES = 2;

  typedef enum logic [1:0] {
    NMI_IDLE    = 2'd0,
    NMI_ASSERT  = 2'd1,
    NMI_RECOVER = 2'd2
  } nmi_state_e;

  // Scans from the top so the lowest set bit is the last one written.
  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    lowest_index = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_index = i[2:0];
    end
  endfunction

endpackage

// File: rtl/cpu6502_edge_detect.sv
// Two-flop synchroniser followed by a rising-edge pulse; advances only on enable_i.
module cpu6502_edge_detect (
  input  logic clock,
  input  logic reset_N,
  input  logic enable_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o
);

  logic [2:0] shift_q;

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      shift_q <= '0;
    end else if (enable_i) begin
      shift_q <= {shift_q[1:0], din_i};
    end
  end

  assign level_o = shift_q[1];
  assign rise_o  = shift_q[1] & ~shift_q[2];

endmodule

// File: rtl/cpu6502_interrupt_controller.sv
// Reset stretcher, IRQ pending/mask reduction and NMI sequencer for a 6502 core.
// Optional level-triggered sources: define CPU6502_INTC_LEVEL_TRIGGER_EN.
module cpu6502_interrupt_controller
  import cpu6502_intc_pkg::*;
#(
  parameter int NUM_SOURCES   = 8,
  parameter int RESET_STRETCH = 8
) (
  input  logic                   clock,
  input  logic                   reset_N,
  input  logic                   enable,
  input  logic [NUM_SOURCES-1:0] irqSource,
  input  logic                   nmiSource,
  input  logic                   softResetRequest,
  input  logic                   nmiAcknowledge,
  input  logic [2:0]             regSelect,
  input  logic                   regWrite,
  input  logic                   regRead,
  input  logic [7:0]             writeData,
  output logic [7:0]             readData,
  output logic                   cpuReset_N,
  output logic                   interrupt_N,
  output logic                   nonMaskableInterrupt_N
);

  localparam int SW = $clog2(RESET_STRETCH + 1);
  localparam logic [1:0] REC_LAST = 2'(NMI_RECOVER_CYCLES - 1);

  logic [SW-1:0] stretch_q, stretch_d;
  logic cpu_rst_n_q, cpu_rst_n_d;

  logic [NUM_SOURCES-1:0] irq_level, irq_rise, irq_set, trig, w1c;
  logic [NUM_SOURCES-1:0] pending_q, pending_d, mask_q;
  logic irq_n_q;
  logic nmi_level, nmi_rise, nmi_trigger;
  nmi_state_e nmi_state_q, nmi_state_d;
  logic [1:0] rec_cnt_q, rec_cnt_d;
  logic nmi_queued_q, nmi_queued_d;
  logic [7:0] pend8, mask8, trig8, active8, rd_val, readData_q;
  logic wr_pending, wr_mask, wr_nmictl;

  assign wr_pending = regWrite && (regSelect == REG_PENDING);
  assign wr_mask    = regWrite && (regSelect == REG_MASK);
  assign wr_nmictl  = regWrite && (regSelect == REG_NMICTL);

  always_comb begin
    stretch_d = stretch_q;
    if (softResetRequest) stretch_d = SW'(RESET_STRETCH);
    else if (stretch_q != '0) stretch_d = stretch_q - SW'(1);
    cpu_rst_n_d = (stretch_d == '0);
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      stretch_q   <= SW'(RESET_STRETCH);
      cpu_rst_n_q <= 1'b0;
    end else if (enable) begin
      stretch_q   <= stretch_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_irq_sync
    cpu6502_edge_detect u_irq_edge (
      .clock    (clock),
      .reset_N  (reset_N),
      .enable_i (enable),
      .din_i    (irqSource[g]),
      .level_o  (irq_level[g]),
      .rise_o   (irq_rise[g])
    );
  end

  cpu6502_edge_detect u_nmi_edge (
    .clock    (clock),
    .reset_N  (reset_N),
    .enable_i (enable),
    .din_i    (nmiSource),
    .level_o  (nmi_level),
    .rise_o   (nmi_rise)
  );

`ifdef CPU6502_INTC_LEVEL_TRIGGER_EN
  logic [NUM_SOURCES-1:0] trigger_q;
  logic wr_trigger;
  assign wr_trigger = regWrite && (regSelect == REG_TRIGGER);

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) trigger_q <= '0;
    else if (enable && wr_trigger) trigger_q <= writeData[NUM_SOURCES-1:0];
  end
  assign trig = trigger_q;
`else
  assign trig = '0;
`endif

  // Level sources re-set every cycle they are high, so a W1C cannot win against them.
  assign irq_set   = (irq_rise & ~trig) | (irq_level & trig);
  assign w1c       = wr_pending ? writeData[NUM_SOURCES-1:0] : '0;
  assign pending_d = (pending_q & ~w1c) | irq_set;

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      pending_q <= '0;
      mask_q    <= '0;
      irq_n_q   <= 1'b1;
    end else if (enable) begin
      pending_q <= pending_d;
      if (wr_mask) mask_q <= writeData[NUM_SOURCES-1:0];
      irq_n_q   <= ~|(pending_q & mask_q);
    end
  end

  assign nmi_trigger = (nmi_rise & nmi_level) | (wr_nmictl & writeData[0]);

  always_comb begin
    nmi_state_d  = nmi_state_q;
    rec_cnt_d    = rec_cnt_q;
    nmi_queued_d = nmi_queued_q;
    case (nmi_state_q)
      NMI_IDLE: begin
        if (nmi_trigger) nmi_state_d = NMI_ASSERT;
      end
      NMI_ASSERT: begin
        if (nmi_trigger) nmi_queued_d = 1'b1;
        if (nmiAcknowledge) begin
          nmi_state_d = NMI_RECOVER;
          rec_cnt_d   = '0;
        end
      end
      NMI_RECOVER: begin
        if (nmi_trigger) nmi_queued_d = 1'b1;
        if (rec_cnt_q == REC_LAST) begin
          if (nmi_queued_q || nmi_trigger) begin
            nmi_state_d  = NMI_ASSERT;
            nmi_queued_d = 1'b0;
          end else begin
            nmi_state_d = NMI_IDLE;
          end
        end else begin
          rec_cnt_d = rec_cnt_q + 2'd1;
        end
      end
      default: nmi_state_d = NMI_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      nmi_state_q  <= NMI_IDLE;
      rec_cnt_q    <= '0;
      nmi_queued_q <= 1'b0;
    end else if (enable) begin
      nmi_state_q  <= nmi_state_d;
      rec_cnt_q    <= rec_cnt_d;
      nmi_queued_q <= nmi_queued_d;
    end
  end

  always_comb begin
    pend8 = '0;
    mask8 = '0;
    trig8 = '0;
    pend8[NUM_SOURCES-1:0] = pending_q;
    mask8[NUM_SOURCES-1:0] = mask_q;
    trig8[NUM_SOURCES-1:0] = trig;
    active8 = pend8 & mask8;
    rd_val  = '0;
    case (regSelect)
      REG_PENDING: rd_val = pend8;
      REG_MASK:    rd_val = mask8;
      REG_STATUS:  rd_val = {|active8, 4'b0000, lowest_index(active8)};
      REG_NMICTL:  rd_val = {6'b000000, nmi_queued_q, nmi_state_q != NMI_IDLE};
      REG_TRIGGER: rd_val = trig8;
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) readData_q <= '0;
    else if (enable && regRead) readData_q <= rd_val;
  end

  // While the CPU is held in reset its interrupt inputs are parked inactive.
  assign readData               = readData_q;
  assign cpuReset_N             = cpu_rst_n_q;
  assign interrupt_N            = irq_n_q | ~cpu_rst_n_q;
  assign nonMaskableInterrupt_N = (nmi_state_q != NMI_ASSERT) | ~cpu_rst_n_q;

endmodule

// File: tb/tb_cpu6502_interrupt_controller.sv
// Self-checking bench: register vector table, directed NMI/reset sequences and a randomised IRQ model.
module tb_cpu6502_interrupt_controller;

  logic       clock = 1'b0;
  logic       reset_N = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] irqSource = '0;
  logic       nmiSource = 1'b0;
  logic       softResetRequest = 1'b0;
  logic       nmiAcknowledge = 1'b0;
  logic [2:0] regSelect = '0;
  logic       regWrite = 1'b0;
  logic       regRead = 1'b0;
  logic [7:0] writeData = '0;
  logic [7:0] readData;
  logic       cpuReset_N, interrupt_N, nonMaskableInterrupt_N;

  cpu6502_interrupt_controller #(.NUM_SOURCES(8), .RESET_STRETCH(8)) dut (
    .clock                  (clock),
    .reset_N                (reset_N),
    .enable                 (enable),
    .irqSource              (irqSource),
    .nmiSource              (nmiSource),
    .softResetRequest       (softResetRequest),
    .nmiAcknowledge         (nmiAcknowledge),
    .regSelect              (regSelect),
    .regWrite               (regWrite),
    .regRead                (regRead),
    .writeData              (writeData),
    .readData               (readData),
    .cpuReset_N             (cpuReset_N),
    .interrupt_N            (interrupt_N),
    .nonMaskableInterrupt_N (nonMaskableInterrupt_N)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] sel;
    logic       do_wr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] d);
    regSelect = sel;
    writeData = d;
    regWrite  = 1'b1;
    tick();
    regWrite  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, output logic [7:0] d);
    regSelect = sel;
    regRead   = 1'b1;
    tick();
    regRead   = 1'b0;
    d = readData;
  endtask

  task automatic wait_cpu_reset(output int n);
    n = 0;
    while (!cpuReset_N && n < 40) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [7:0] model_status(input logic [7:0] act);
    logic [7:0] s;
    s = '0;
    if (act != 0) begin
      s[7] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (act[i]) begin
          s[2:0] = 3'(i);
          break;
        end
      end
    end
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int n;
    logic [7:0] m_pend, m_mask, m_rd, h1, h2, h3, src, wd, act, edge_v;
    logic m_irqn, en;
    int op;

    vecs[0]  = '{3'd0, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{3'd1, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{3'd2, 1'b0, 8'h00, 8'h00};
    vecs[3]  = '{3'd3, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{3'd1, 1'b1, 8'hA5, 8'hA5};
    vecs[5]  = '{3'd0, 1'b1, 8'hFF, 8'h00};
    vecs[6]  = '{3'd5, 1'b1, 8'hFF, 8'h00};
    vecs[7]  = '{3'd6, 1'b1, 8'hFF, 8'h00};
    vecs[8]  = '{3'd7, 1'b1, 8'h5A, 8'h00};
    vecs[9]  = '{3'd3, 1'b1, 8'hFE, 8'h00};
    vecs[10] = '{3'd1, 1'b1, 8'h00, 8'h00};
    vecs[11] = '{3'd4, 1'b0, 8'h00, 8'h00};

    // Reset values and stretch after release
    #2;
    chk("rst_cpuReset_N", cpuReset_N, 1'b0);
    chk("rst_interrupt_N", interrupt_N, 1'b1);
    chk("rst_nmi_N", nonMaskableInterrupt_N, 1'b1);
    chk("rst_readData", readData, 8'h00);
    ticks(3);
    reset_N = 1'b1;
    wait_cpu_reset(n);
    chk("rst_stretch_cycles", n, 8);

    softResetRequest = 1'b1;
    tick();
    softResetRequest = 1'b0;
    chk("soft_rst_low", cpuReset_N, 1'b0);
    wait_cpu_reset(n);
    chk("soft_rst_cycles", n, 8);

    // Register map table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].sel, vecs[i].wdata);
      rd(vecs[i].sel, d);
      chk($sformatf("regvec%0d", i), d, vecs[i].exp);
    end

    // Masked IRQ, status, W1C latency
    wr(3'd1, 8'h05);
    irqSource[2] = 1'b1;
    ticks(3);
    irqSource[2] = 1'b0;
    ticks(2);
    rd(3'd0, d);
    chk("irq2_pending", d, 8'h04);
    rd(3'd2, d);
    chk("irq2_status", d, 8'h82);
    chk("irq2_interrupt_N", interrupt_N, 1'b0);
    wr(3'd0, 8'h04);
    chk("w1c_irq_still_low", interrupt_N, 1'b0);
    tick();
    chk("w1c_irq_high", interrupt_N, 1'b1);

    // Set and clear in the same cycle
    irqSource[0] = 1'b1;
    ticks(2);
    wr(3'd0, 8'h01);
    rd(3'd0, d);
    chk("set_wins", d, 8'h01);
    irqSource[0] = 1'b0;
    wr(3'd0, 8'h01);
    rd(3'd0, d);
    chk("set_wins_cleanup", d, 8'h00);

    // NMI assert / ack / recovery
    nmiSource = 1'b1;
    ticks(3);
    chk("nmi_assert", nonMaskableInterrupt_N, 1'b0);
    ticks(2);
    chk("nmi_hold", nonMaskableInterrupt_N, 1'b0);
    nmiAcknowledge = 1'b1;
    tick();
    nmiAcknowledge = 1'b0;
    chk("nmi_recover1", nonMaskableInterrupt_N, 1'b1);
    rd(3'd3, d);
    chk("nmictl_recover", d, 8'h01);
    chk("nmi_recover2", nonMaskableInterrupt_N, 1'b1);
    tick();
    rd(3'd3, d);
    chk("nmictl_idle", d, 8'h00);

    // Queued NMI re-asserts after recovery without a fresh ack
    nmiSource = 1'b0;
    ticks(3);
    nmiSource = 1'b1;
    ticks(3);
    chk("nmi2_assert", nonMaskableInterrupt_N, 1'b0);
    nmiSource = 1'b0;
    ticks(3);
    nmiSource = 1'b1;
    ticks(3);
    rd(3'd3, d);
    chk("nmictl_queued", d, 8'h03);
    nmiAcknowledge = 1'b1;
    tick();
    nmiAcknowledge = 1'b0;
    chk("nmi2_rec1", nonMaskableInterrupt_N, 1'b1);
    tick();
    chk("nmi2_rec2", nonMaskableInterrupt_N, 1'b1);
    tick();
    chk("nmi_requeue_assert", nonMaskableInterrupt_N, 1'b0);
    rd(3'd3, d);
    chk("nmictl_queue_cleared", d, 8'h01);
    nmiAcknowledge = 1'b1;
    tick();
    nmiAcknowledge = 1'b0;
    ticks(2);
    chk("nmi_back_idle", nonMaskableInterrupt_N, 1'b1);

    // Software NMI, then reset in the middle of ASSERT
    wr(3'd3, 8'h01);
    chk("sw_nmi_assert", nonMaskableInterrupt_N, 1'b0);
    irqSource[2] = 1'b1;
    ticks(4);
    chk("pre_reset_irq_low", interrupt_N, 1'b0);
    rd(3'd3, d);
    reset_N = 1'b0;
    #1;
    chk("midrst_cpuReset_N", cpuReset_N, 1'b0);
    chk("midrst_interrupt_N", interrupt_N, 1'b1);
    chk("midrst_nmi_N", nonMaskableInterrupt_N, 1'b1);
    chk("midrst_readData", readData, 8'h00);
    irqSource = '0;
    nmiSource = 1'b0;
    ticks(2);
    reset_N = 1'b1;
    wait_cpu_reset(n);
    chk("midrst_stretch", n, 8);
    rd(3'd3, d);
    chk("midrst_nmictl", d, 8'h00);
    rd(3'd0, d);
    chk("midrst_pending", d, 8'h00);
    rd(3'd1, d);
    chk("midrst_mask", d, 8'h00);

    // Randomised IRQ traffic against a delay-line model (edge becomes pending 3 enabled clocks later)
    m_pend = '0; m_mask = '0; m_rd = 8'h00; m_irqn = 1'b1;
    h1 = '0; h2 = '0; h3 = '0; src = '0;
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) src = 8'($urandom);
      op = int'($urandom_range(0, 5));
      wd = 8'($urandom);
      enable    = en;
      irqSource = src;
      writeData = wd;
      regWrite  = (op == 1 || op == 2);
      regRead   = (op >= 3);
      case (op)
        1: regSelect = 3'd1;
        2: regSelect = 3'd0;
        3: regSelect = 3'd0;
        4: regSelect = 3'd2;
        5: regSelect = 3'd1;
        default: regSelect = 3'd7;
      endcase
      if (en) begin
        edge_v = h2 & ~h3;
        act = m_pend & m_mask;
        if (op == 3) m_rd = m_pend;
        if (op == 4) m_rd = model_status(act);
        if (op == 5) m_rd = m_mask;
        m_irqn = (act == 0);
        m_pend = (m_pend & ~((op == 2) ? wd : 8'h00)) | edge_v;
        if (op == 1) m_mask = wd;
        h3 = h2; h2 = h1; h1 = src;
      end
      tick();
      chk("rand_interrupt_N", interrupt_N, m_irqn);
      chk("rand_readData", readData, m_rd);
    end
    enable = 1'b1;
    regWrite = 1'b0;
    regRead = 1'b0;
    irqSource = '0;
    ticks(4);
    wr(3'd0, 8'hFF);

    // Trigger register
`ifdef CPU6502_INTC_LEVEL_TRIGGER_EN
    wr(3'd4, 8'h02);
    rd(3'd4, d);
    chk("trigger_rw", d, 8'h02);
    irqSource[1] = 1'b1;
    ticks(4);
    wr(3'd0, 8'h02);
    rd(3'd0, d);
    chk("level_w1c_blocked", d, 8'h02);
    irqSource[1] = 1'b0;
    ticks(4);
    wr(3'd0, 8'h02);
    rd(3'd0, d);
    chk("level_w1c_clears", d, 8'h00);
`else
    wr(3'd4, 8'hFF);
    rd(3'd4, d);
    chk("trigger_reads_zero", d, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
